// File: rtl/hall_decoder.sv
// hall_decoder: hall-sensor sync/debounce, sector tracking, position/direction and skip/invalid detection.
// Step-period measurement and stall flag are built only when HALL_DECODER_VELOCITY_EN is defined.
`default_nettype none

module hall_decoder #(
  parameter int DEBOUNCE_CYCLES = 16,
  parameter int PERIOD_WIDTH    = 24
) (
  input  logic                    CLK,
  input  logic                    reset_n,
  input  logic                    hall1,
  input  logic                    hall2,
  input  logic                    hall3,
  input  logic                    clear_position,
  output logic signed [31:0]      position,
  output logic                    direction,
  output logic                    step_strobe,
  output logic [PERIOD_WIDTH-1:0] period,
  output logic                    period_valid,
  output logic                    stalled,
  output logic                    hall_error
);

  localparam logic [7:0] DEB_LIMIT = 8'(DEBOUNCE_CYCLES);

  typedef enum logic {INIT = 1'b0, TRACK = 1'b1} state_t;

  state_t     state;
  logic [2:0] sync1;
  logic [2:0] sync2;
  logic [2:0] cand;
  logic [2:0] accepted;
  logic [2:0] sector;
  logic [7:0] stable_cnt;

  logic       accept;
  logic       code_valid;
  logic [2:0] new_sector;
  logic [3:0] diff;
  logic       step_fwd;
  logic       step_rev;

  function automatic logic [2:0] sector_of(input logic [2:0] code);
    case (code)
      3'b101:  sector_of = 3'd0;
      3'b100:  sector_of = 3'd1;
      3'b110:  sector_of = 3'd2;
      3'b010:  sector_of = 3'd3;
      3'b011:  sector_of = 3'd4;
      3'b001:  sector_of = 3'd5;
      default: sector_of = 3'd0;
    endcase
  endfunction

  always_comb begin
    accept     = (stable_cnt == DEB_LIMIT) && (cand != accepted);
    code_valid = (cand != 3'b000) && (cand != 3'b111);
    new_sector = sector_of(cand);
    // Forward distance from the stored sector, modulo 6.
    diff = {1'b0, new_sector} + 4'd6 - {1'b0, sector};
    if (diff >= 4'd6) begin
      diff = diff - 4'd6;
    end
    step_fwd = accept && (state == TRACK) && code_valid && (diff == 4'd1);
    step_rev = accept && (state == TRACK) && code_valid && (diff == 4'd5);
  end

  always_ff @(posedge CLK or negedge reset_n) begin
    if (!reset_n) begin
      sync1       <= 3'b000;
      sync2       <= 3'b000;
      cand        <= 3'b000;
      accepted    <= 3'b000;
      stable_cnt  <= 8'd0;
      sector      <= 3'd0;
      state       <= INIT;
      position    <= 32'sd0;
      direction   <= 1'b0;
      step_strobe <= 1'b0;
      hall_error  <= 1'b0;
    end else begin
      sync1 <= {hall1, hall2, hall3};
      sync2 <= sync1;

      if (sync2 != cand) begin
        cand       <= sync2;
        stable_cnt <= 8'd1;
      end else if (stable_cnt != DEB_LIMIT) begin
        stable_cnt <= stable_cnt + 8'd1;
      end

      step_strobe <= 1'b0;
      hall_error  <= 1'b0;

      if (accept) begin
        accepted <= cand;
        case (state)
          INIT: begin
            if (code_valid) begin
              sector <= new_sector;
              state  <= TRACK;
            end else begin
              hall_error <= 1'b1;
            end
          end
          TRACK: begin
            if (!code_valid) begin
              hall_error <= 1'b1;
              state      <= INIT;
            end else begin
              sector <= new_sector;
              if (step_fwd || step_rev) begin
                step_strobe <= 1'b1;
                direction   <= step_fwd;
              end else begin
                hall_error <= 1'b1;
              end
            end
          end
          default: state <= INIT;
        endcase
      end

      if (clear_position) begin
        position <= 32'sd0;
      end else if (step_fwd) begin
        position <= position + 32'sd1;
      end else if (step_rev) begin
        position <= position - 32'sd1;
      end
    end
  end

`ifdef HALL_DECODER_VELOCITY_EN
  localparam logic [PERIOD_WIDTH-1:0] PMAX = '1;
  localparam logic [PERIOD_WIDTH-1:0] PONE = PERIOD_WIDTH'(1);

  logic [PERIOD_WIDTH-1:0] pcnt;
  logic                    dir_ok;
  logic                    step;
  logic                    skip;
  logic                    leave;

  assign step  = step_fwd || step_rev;
  assign skip  = accept && (state == TRACK) && code_valid && !step;
  assign leave = accept && (state == TRACK) && !code_valid;

  always_ff @(posedge CLK or negedge reset_n) begin
    if (!reset_n) begin
      pcnt         <= '0;
      period       <= '0;
      period_valid <= 1'b0;
      stalled      <= 1'b1;
      dir_ok       <= 1'b0;
    end else begin
      if (step || skip) begin
        pcnt <= PONE;
      end else if (pcnt != PMAX) begin
        pcnt <= pcnt + PONE;
      end

      if (step) begin
        stalled <= 1'b0;
        dir_ok  <= 1'b1;
        // A period is only meaningful between two steps in the same direction.
        if (dir_ok && (step_fwd == direction)) begin
          period       <= pcnt;
          period_valid <= 1'b1;
        end else begin
          period_valid <= 1'b0;
        end
      end else begin
        if (pcnt == PMAX) begin
          stalled      <= 1'b1;
          period_valid <= 1'b0;
        end
        if (skip || leave) begin
          period_valid <= 1'b0;
        end
        if (leave) begin
          dir_ok <= 1'b0;
        end
      end
    end
  end
`else
  assign period       = '0;
  assign period_valid = 1'b0;
  assign stalled      = 1'b0;
`endif

endmodule

`default_nettype wire

// File: doc/hall_decoder.md
# hall_decoder

Decodes the three motor hall-sensor inputs into a signed 32-bit rotor position count, a direction flag and a per-step period measurement. Sits between the hall pins and the position controller: its `position` output is the `state` feedback the PID/commutation block compares against its setpoint. Input sync and debounce, sector tracking, skip/invalid-code detection and stall detection all live here.

## Interface
- `DEBOUNCE_CYCLES`, default 16: consecutive identical synchronized samples required before a new hall code is accepted; legal range 1..255.
- `PERIOD_WIDTH`, default 24: width of the step-period counter and `period` output.
- `CLK`  in  1  system clock; all logic is on the rising edge.
- `reset_n`  in  1  asynchronous, active-low reset.
- `hall1`, `hall2`, `hall3`  in  1 each  raw, asynchronous hall sensor inputs.
- `clear_position`  in  1  synchronous request to zero `position`.
- `position`  out  32 signed  accumulated step count (+1 forward, -1 reverse).
- `direction`  out  1  direction of the last valid step (1 = forward).
- `step_strobe`  out  1  one-cycle pulse for each accepted valid step.
- `period`  out  PERIOD_WIDTH  CLK cycles between the last two same-direction steps.
- `period_valid`  out  1  `period` holds a current measurement.
- `stalled`  out  1  period counter saturated, or no measurement yet.
- `hall_error`  out  1  one-cycle pulse on an invalid code or a skipped sector.

## Operation
- Sync: each hall input passes through a 2-FF synchronizer. `code = {hall1,hall2,hall3}`.
- Debounce: a candidate code and a stability counter are kept. A synchronized code differing from the candidate reloads the candidate and resets the counter. A code is accepted when it has been stable for DEBOUNCE_CYCLES samples and differs from the last accepted code. Each code is accepted once.
- Sector map (forward order): 101=0, 100=1, 110=2, 010=3, 011=4, 001=5, then wraps to 0. Codes 000 and 111 are invalid.
- FSM `INIT`: no reference sector is held.
  - An accepted valid code stores the sector and moves to `TRACK`. No step, no strobe.
  - An invalid code pulses `hall_error` and stays in `INIT`.
- FSM `TRACK`: compare the new sector with the stored sector.
  - +1 mod 6: `position`+1, `direction`=1, `step_strobe`.
  - -1 mod 6: `position`-1, `direction`=0, `step_strobe`.
  - ±2 or 3: `hall_error`, stored sector updated, no position change, `period_valid` cleared, period counter restarted.
  - Invalid code: `hall_error`, go to `INIT`, `period_valid` cleared.
- `position` wraps in two's complement (0x7FFFFFFF+1 = 0x80000000).
- `clear_position` sets `position` to 0 on the next edge. If it coincides with a step, clear wins for `position`; `direction`, `step_strobe` and the period logic still update.
- Period counter: increments every cycle and saturates at all-ones.
  - On a valid step it restarts at 1.
  - If the step has the same direction as the previous valid step, `period` ← counter value and `period_valid` ← 1.
  - If the direction reverses, or it is the first step after `INIT`, `period_valid` ← 0.
  - On saturation, `stalled` ← 1 and `period_valid` ← 0. `stalled` clears on the next valid step.
- Reset values:
  - `position`=0, `direction`=0, `step_strobe`=0, `hall_error`=0, `period`=0, `period_valid`=0, `stalled`=1.
  - FSM in `INIT`, synchronizers and candidate cleared to 000.
- Asserting `reset_n` low mid-operation clears everything immediately, including an in-progress debounce.

## Timing
- Latency: a hall change stable from edge k gives `step_strobe`/`position` update visible after edge k+DEBOUNCE_CYCLES+2 (2 sync, DEBOUNCE_CYCLES stability, 1 register).
- Pulses shorter than DEBOUNCE_CYCLES synchronized cycles produce no output.
- `step_strobe` and `hall_error` are exactly one cycle wide and are never asserted together.
- `period`, `period_valid`, `direction` and `position` update on the same edge as `step_strobe`.
- Maximum tracked step rate is one step per DEBOUNCE_CYCLES+1 cycles.

## Configuration
- `HALL_DECODER_VELOCITY_EN` defined: the period counter, `period`, `period_valid` and `stalled` are implemented as described above.
- Undefined: no period counter is synthesized. `period`=0, `period_valid`=0 and `stalled`=0 constantly. Position, direction, strobe and error behaviour are unchanged.

## Test plan
- Reset release, then forward sequence 101→100→110→010→011→001→101, each held 100 cycles (DEBOUNCE_CYCLES=16) → first code gives no strobe; 6 strobes; `position`=6; `direction`=1; from the second step, `period`=100 with `period_valid`=1.
- Reverse three sectors from 101 (101→001→011→010) → `position` decrements by 3, `direction`=0, `period_valid`=0 on the reversal step.
- 5-cycle glitch 101→100→101 → no strobe, no error, `position` unchanged.
- Jump 101→110 (skip), then 000 → two `hall_error` pulses, `position` unchanged, FSM returns to `INIT`; the next valid code gives no strobe.
- `position` preloaded to 0x7FFFFFFF by stepping, plus one forward step → 0x80000000. `clear_position` asserted on the same edge as a step → `position`=0 and `step_strobe`=1.
- PERIOD_WIDTH=8, hall held static for more than 255 cycles after steps → `stalled`=1, `period_valid`=0. With the macro undefined → `period`=0 throughout.
